// File: rtl/alu_param_pkg.sv
// Shared definitions for the parametrised clock-gated ALU: opcodes, FSM states,
// CMP result bit positions and flag bit positions (flags exist only when the
// ALU_FLAGS_EN macro is defined in the top).
package alu_param_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_CMP  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_AND  = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_OR   = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1001;
   localparam logic [3:0] OP_SHL  = 4'b1010;
   localparam logic [3:0] OP_SHR  = 4'b1011;
   localparam logic [3:0] OP_ROL  = 4'b1100;
   localparam logic [3:0] OP_ROR  = 4'b1101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } alu_state_e;

   // CMP result bits in Z_low
   localparam int CMP_LT = 0;
   localparam int CMP_EQ = 1;
   localparam int CMP_GT = 2;

   // flags = {dz, ov, neg, zero}
   localparam int FLAG_ZERO = 0;
   localparam int FLAG_NEG  = 1;
   localparam int FLAG_OV   = 2;
   localparam int FLAG_DZ   = 3;

endpackage

// File: rtl/alu_param_cg_cg_cell.sv
// Latch-based integrated clock gate: enable is captured while clk is low so
// gclk can only produce whole, glitch-free high pulses.
module cg_cell (
   input  logic clk,
   input  logic en,
   output logic gclk
);

   logic en_lat;

   // Transparent-low enable latch
   always_latch begin
      if (!clk) begin
         en_lat <= en;
      end
   end

   assign gclk = clk & en_lat;

endmodule

// File: rtl/alu_param_cg.sv
// alu_param_cg: W-bit clock-gated ALU with single-cycle ops and iterative
// radix-2 multiply / restoring divide (double-width result Z_high:Z_low).
// Optional macro ALU_FLAGS_EN adds the flags[3:0] = {dz, ov, neg, zero} port.
module alu_param_cg
   import alu_param_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         start,
   input  logic         sgn,
   input  logic [3:0]   op,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Z_low,
   output logic [W-1:0] Z_high,
   output logic         valid,
   output logic         busy
`ifdef ALU_FLAGS_EN
   ,
   output logic [3:0]   flags
`endif
);

   localparam int CW = $clog2(W) + 1;
   localparam int SW = $clog2(W);
   localparam logic [W-1:0]   ZERO_W = {W{1'b0}};
   localparam logic [W-1:0]   ONES_W = {W{1'b1}};
   localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

   logic gclk;

   cg_cell u_cg (
      .clk  (clk),
      .en   (en),
      .gclk (gclk)
   );

   alu_state_e     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] prod_q, prod_d;   // MUL: {acc, multiplier}; DIV: {remainder, quotient}
   logic [W-1:0]   dvs_q, dvs_d;     // multiplicand or divisor magnitude
   logic           is_div_q, is_div_d;
   logic           qneg_q, qneg_d;   // product / quotient negative
   logic           rneg_q, rneg_d;   // remainder negative
   logic [W-1:0]   zl_q, zl_d;
   logic [W-1:0]   zh_q, zh_d;
   logic           valid_q, valid_d;
   logic           busy_q, busy_d;

   logic [W:0]     ext_a_s, ext_b_s, addsub_s;
   logic [W-1:0]   abs_a_s, abs_b_s;
   logic           lt_s, eq_s, gt_s;
   logic [W-1:0]   cmp_s;
   logic [SW-1:0]  amt_s;
   logic [SW:0]    inv_amt_s;
   logic [W-1:0]   rol_s, ror_s;
   logic [W:0]     mul_sum_s, div_tmp_s;
   logic [W-1:0]   div_diff_s;
   logic           div_ge_s;
   logic [2*W-1:0] prod_fix_s;
   logic [W-1:0]   quot_fix_s, rem_fix_s;

   // Single-cycle datapath: add/sub, compare, rotates, operand magnitudes
   always_comb begin
      ext_a_s  = sgn ? {A[W-1], A} : {1'b0, A};
      ext_b_s  = sgn ? {B[W-1], B} : {1'b0, B};
      if (op == OP_SUB) begin
         addsub_s = ext_a_s - ext_b_s;
      end else begin
         addsub_s = ext_a_s + ext_b_s;
      end
      abs_a_s  = (sgn && A[W-1]) ? (~A + ONE_W) : A;
      abs_b_s  = (sgn && B[W-1]) ? (~B + ONE_W) : B;
      lt_s     = sgn ? ($signed(A) < $signed(B)) : (A < B);
      eq_s     = (A == B);
      gt_s     = sgn ? ($signed(A) > $signed(B)) : (A > B);
      cmp_s         = ZERO_W;
      cmp_s[CMP_LT] = lt_s;
      cmp_s[CMP_EQ] = eq_s;
      cmp_s[CMP_GT] = gt_s;
      amt_s     = B[SW-1:0];
      inv_amt_s = (SW+1)'(W) - (SW+1)'(amt_s);
      rol_s     = (A << amt_s) | (A >> inv_amt_s);
      ror_s     = (A >> amt_s) | (A << inv_amt_s);
   end

   // Iterative datapath step and final sign correction
   always_comb begin
      mul_sum_s  = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? dvs_q : ZERO_W)};
      div_tmp_s  = {prod_q[2*W-1:W], prod_q[W-1]};
      div_ge_s   = (div_tmp_s >= {1'b0, dvs_q});
      div_diff_s = div_tmp_s[W-1:0] - dvs_q;
      prod_fix_s = qneg_q ? (~prod_q + ONE_2W) : prod_q;
      quot_fix_s = qneg_q ? (~prod_q[W-1:0] + ONE_W) : prod_q[W-1:0];
      rem_fix_s  = rneg_q ? (~prod_q[2*W-1:W] + ONE_W) : prod_q[2*W-1:W];
   end

   // Next-state logic for the FSM and all result registers
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      dvs_d    = dvs_q;
      is_div_d = is_div_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      zl_d     = zl_q;
      zh_d     = zh_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               valid_d = 1'b1;
               zh_d    = ZERO_W;
               case (op)
                  OP_ADD, OP_SUB: begin
                     zl_d = addsub_s[W-1:0];
                     zh_d = {W{addsub_s[W]}};
                  end
                  OP_MUL: begin
                     valid_d  = 1'b0;
                     zh_d     = zh_q;
                     prod_d   = {ZERO_W, abs_b_s};
                     dvs_d    = abs_a_s;
                     is_div_d = 1'b0;
                     qneg_d   = sgn & (A[W-1] ^ B[W-1]);
                     rneg_d   = 1'b0;
                     cnt_d    = CW'(W);
                     busy_d   = 1'b1;
                     state_d  = MUL;
                  end
                  OP_DIV: begin
                     if (B == ZERO_W) begin
                        zl_d = ONES_W;
                        zh_d = A;
                     end else begin
                        valid_d  = 1'b0;
                        zh_d     = zh_q;
                        prod_d   = {ZERO_W, abs_a_s};
                        dvs_d    = abs_b_s;
                        is_div_d = 1'b1;
                        qneg_d   = sgn & (A[W-1] ^ B[W-1]);
                        rneg_d   = sgn & A[W-1];
                        cnt_d    = CW'(W);
                        busy_d   = 1'b1;
                        state_d  = DIV;
                     end
                  end
                  OP_CMP:  zl_d = cmp_s;
                  OP_NAND: zl_d = ~(A & B);
                  OP_AND:  zl_d = A & B;
                  OP_NOR:  zl_d = ~(A | B);
                  OP_OR:   zl_d = A | B;
                  OP_XOR:  zl_d = A ^ B;
                  OP_SHL:  zl_d = A << amt_s;
                  OP_SHR:  zl_d = A >> amt_s;
                  OP_ROL:  zl_d = rol_s;
                  OP_ROR:  zl_d = ror_s;
                  default: zl_d = ZERO_W;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         MUL: begin
            prod_d = {mul_sum_s, prod_q[W-1:1]};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end else begin
               state_d = MUL;
            end
         end
         DIV: begin
            if (div_ge_s) begin
               prod_d = {div_diff_s, prod_q[W-2:0], 1'b1};
            end else begin
               prod_d = {div_tmp_s[W-1:0], prod_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end else begin
               state_d = DIV;
            end
         end
         DONE: begin
            if (is_div_q) begin
               zl_d = quot_fix_s;
               zh_d = rem_fix_s;
            end else begin
               zl_d = prod_fix_s[W-1:0];
               zh_d = prod_fix_s[2*W-1:W];
            end
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Core state and output registers on the gated clock
   always_ff @(posedge gclk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= {CW{1'b0}};
         prod_q   <= {(2*W){1'b0}};
         dvs_q    <= ZERO_W;
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         zl_q     <= ZERO_W;
         zh_q     <= ZERO_W;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         dvs_q    <= dvs_d;
         is_div_q <= is_div_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         zl_q     <= zl_d;
         zh_q     <= zh_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign Z_low  = zl_q;
   assign Z_high = zh_q;
   assign valid  = valid_q;
   assign busy   = busy_q;

`ifdef ALU_FLAGS_EN
   logic       sgn_q, sgn_d;
   logic [3:0] flags_q, flags_d;
   logic       ov_s, dz_s;

   // Flags are recomputed whenever a result is written (valid issued), held otherwise
   always_comb begin
      if ((state_q == IDLE) && start && (op == OP_MUL)) begin
         sgn_d = sgn;
      end else begin
         sgn_d = sgn_q;
      end
      dz_s = (state_q == IDLE) && start && (op == OP_DIV) && (B == ZERO_W);
      if ((state_q == IDLE) && start && ((op == OP_ADD) || (op == OP_SUB))) begin
         ov_s = sgn & (addsub_s[W] ^ addsub_s[W-1]);
      end else if ((state_q == DONE) && !is_div_q) begin
         if (sgn_q) begin
            ov_s = (prod_fix_s[2*W-1:W] != {W{prod_fix_s[W-1]}});
         end else begin
            ov_s = (prod_fix_s[2*W-1:W] != ZERO_W);
         end
      end else begin
         ov_s = 1'b0;
      end
      flags_d = flags_q;
      if (valid_d) begin
         flags_d[FLAG_DZ]   = dz_s;
         flags_d[FLAG_OV]   = ov_s;
         flags_d[FLAG_NEG]  = zl_d[W-1];
         flags_d[FLAG_ZERO] = (zl_d == ZERO_W);
      end else begin
         flags_d = flags_q;
      end
   end

   // Flag and captured-mode registers
   always_ff @(posedge gclk or negedge rst) begin
      if (!rst) begin
         sgn_q   <= 1'b0;
         flags_q <= 4'b0000;
      end else begin
         sgn_q   <= sgn_d;
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_param_cg.sv
// Directed, scoreboard-checked bench for alu_param_cg at W=16.
module tb_alu_param_cg;
   import alu_param_pkg::*;

   logic        clk;
   logic        rst;
   logic        en;
   logic        start;
   logic        sgn;
   logic [3:0]  op;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] Z_low;
   logic [15:0] Z_high;
   logic        valid;
   logic        busy;
`ifdef ALU_FLAGS_EN
   logic [3:0]  flags;
`endif

   alu_param_cg #(.W(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .start  (start),
      .sgn    (sgn),
      .op     (op),
      .A      (A),
      .B      (B),
      .Z_low  (Z_low),
      .Z_high (Z_high),
      .valid  (valid),
      .busy   (busy)
`ifdef ALU_FLAGS_EN
      ,
      .flags  (flags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [15:0] lo;
      logic [15:0] hi;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one operation, optionally gating or re-pulsing start while it runs,
   // then compare against the scoreboard entry once valid appears.
   task automatic run_op(input string tag, input logic [3:0] o, input logic s,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] lo, input logic [15:0] hi, input int lat,
                         input int gate_at, input int gate_len, input int restart_at);
      exp_t        e;
      exp_t        got;
      int          n;
      logic        seen_busy;
      logic        frozen_ok;
      logic [15:0] zl_snap;
      logic [15:0] zh_snap;
      e.tag = tag; e.lo = lo; e.hi = hi; e.lat = lat;
      sb_q.push_back(e);
      @(negedge clk);
      op = o; sgn = s; A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op = 4'hF; A = ~a; B = ~b; sgn = ~s;
      n = 0;
      seen_busy = busy;
      frozen_ok = 1'b1;
      zl_snap = Z_low;
      zh_snap = Z_high;
      while (valid !== 1'b1 && n < 100) begin
         if (n == gate_at) begin
            en = 1'b0; zl_snap = Z_low; zh_snap = Z_high;
         end
         if (n == restart_at) begin
            op = OP_ADD; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
         seen_busy = seen_busy | busy;
         if (gate_at >= 0 && n > gate_at && n <= gate_at + gate_len) begin
            if (Z_low !== zl_snap || Z_high !== zh_snap || busy !== 1'b1 || valid !== 1'b0)
               frozen_ok = 1'b0;
            if (n == gate_at + gate_len) en = 1'b1;
         end
      end
      start = 1'b0;
      en = 1'b1;
      got = sb_q.pop_front();
      chk({got.tag, " valid"}, {31'd0, valid}, 32'd1);
      chk({got.tag, " lo"}, {16'd0, Z_low}, {16'd0, got.lo});
      chk({got.tag, " hi"}, {16'd0, Z_high}, {16'd0, got.hi});
      chk({got.tag, " latency"}, n, got.lat);
      chk({got.tag, " busy seen"}, {31'd0, seen_busy}, (got.lat > 0) ? 32'd1 : 32'd0);
      chk({got.tag, " busy at valid"}, {31'd0, busy}, 32'd0);
      if (gate_at >= 0) chk({got.tag, " frozen"}, {31'd0, frozen_ok}, 32'd1);
      @(negedge clk);
      chk({got.tag, " pulse"}, {31'd0, valid}, 32'd0);
   endtask

   initial begin
      int vcount;
      rst = 1'b1; en = 1'b1; start = 1'b0; sgn = 1'b0; op = 4'h0; A = 16'h0; B = 16'h0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset Z_low", {16'd0, Z_low}, 32'd0);
      chk("reset Z_high", {16'd0, Z_high}, 32'd0);
      chk("reset valid", {31'd0, valid}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;

      run_op("add ovf", OP_ADD, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, -1, 0, -1);
`ifdef ALU_FLAGS_EN
      chk("add flags", {28'd0, flags}, 32'h6);
`endif
      run_op("sub neg", OP_SUB, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 16'hFFFF, 0, -1, 0, -1);
      run_op("mul s", OP_MUL, 1'b1, 16'hC568, 16'hD120, 16'h9500, 16'h0ABA, 17, -1, 0, -1);
      run_op("mul gated", OP_MUL, 1'b1, 16'hC568, 16'hD120, 16'h9500, 16'h0ABA, 27, 5, 10, -1);
      run_op("div s1", OP_DIV, 1'b1, 16'h0064, 16'hFFFD, 16'hFFDF, 16'h0001, 17, -1, 0, -1);
      run_op("div s2", OP_DIV, 1'b1, 16'hFF9C, 16'hFFFD, 16'h0021, 16'hFFFF, 17, -1, 0, -1);
      run_op("div u", OP_DIV, 1'b0, 16'hFFFF, 16'h0002, 16'h7FFF, 16'h0001, 17, -1, 0, -1);
      run_op("div zero", OP_DIV, 1'b0, 16'h000F, 16'h0000, 16'hFFFF, 16'h000F, 0, -1, 0, -1);
`ifdef ALU_FLAGS_EN
      chk("div zero flags", {28'd0, flags}, 32'hA);
`endif
      run_op("mul restart", OP_MUL, 1'b0, 16'd300, 16'd400, 16'hD4C0, 16'h0001, 17, -1, 0, 4);
      vcount = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid === 1'b1) vcount++;
      end
      chk("mul restart extra valid", vcount, 0);

      run_op("rol", OP_ROL, 1'b0, 16'h0F0F, 16'h0004, 16'hF0F0, 16'h0000, 0, -1, 0, -1);
      run_op("ror", OP_ROR, 1'b0, 16'h0F0F, 16'h0001, 16'h8787, 16'h0000, 0, -1, 0, -1);
      run_op("cmp s", OP_CMP, 1'b1, 16'hCFC7, 16'h2710, 16'h0001, 16'h0000, 0, -1, 0, -1);
      run_op("cmp u", OP_CMP, 1'b0, 16'hCFC7, 16'h2710, 16'h0004, 16'h0000, 0, -1, 0, -1);
      run_op("reserved", 4'hE, 1'b0, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 0, -1, 0, -1);
      run_op("xor", OP_XOR, 1'b0, 16'hAAAA, 16'h0FF0, 16'hA55A, 16'h0000, 0, -1, 0, -1);

      // Abort a divide with reset: everything clears and no valid follows
      @(negedge clk);
      op = OP_DIV; sgn = 1'b0; A = 16'h1000; B = 16'h0003; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst mid-div Z_low", {16'd0, Z_low}, 32'd0);
      chk("rst mid-div Z_high", {16'd0, Z_high}, 32'd0);
      chk("rst mid-div busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      vcount = 0;
      repeat (25) begin
         @(negedge clk);
         if (valid === 1'b1 || busy === 1'b1) vcount++;
      end
      chk("rst mid-div no valid", vcount, 0);

      run_op("after rst", OP_AND, 1'b0, 16'hFF00, 16'h0FF0, 16'h0F00, 16'h0000, 0, -1, 0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
